spw_tx_arbiter: RTL

//  Packet-atomic two-requester arbiter in front of the SpaceWire TX FIFO. Host port (req0) and

---
 rtl/spw_tx_arbiter_if.sv | 29 ++
 rtl/spw_tx_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/spw_tx_arbiter_if.sv
// Bundle of the two requester ports and the TX FIFO write port shared by
// the SpaceWire TX arbiter. The arbiter connects through the slave modport;
// whatever drives the requests and models the FIFO uses the master modport.
interface spw_tx_arbiter_if #(
   parameter int DWIDTH = 9
);
   logic              req0_valid;
   logic [DWIDTH-1:0] req0_data;
   logic              req0_ack;
   logic              req1_valid;
   logic [DWIDTH-1:0] req1_data;
   logic              req1_ack;
   logic              fifo_full;
   logic              fifo_wr_en;
   logic [DWIDTH-1:0] fifo_data;
   logic [1:0]        grant;
   logic              timeout_err;
   logic [7:0]        err_cnt;

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, fifo_full,
      output req0_ack, req1_ack, fifo_wr_en, fifo_data, grant, timeout_err, err_cnt
   );

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, fifo_full,
      input  req0_ack, req1_ack, fifo_wr_en, fifo_data, grant, timeout_err, err_cnt
   );
endinterface

// File: rtl/spw_tx_arbiter.sv
// Packet-atomic two-requester arbiter in front of the SpaceWire TX FIFO.
// A requester keeps the grant from its first word until its EOP/EEP has been
// written. Each word goes out as a one-cycle write strobe followed by an ack
// cycle and a gap cycle. An owner that leaves its valid low for TIMEOUT WAIT
// cycles has its packet closed with an injected EEP and loses the grant.
module spw_tx_arbiter #(
   parameter int DWIDTH  = 9,
   parameter int TIMEOUT = 1024,
   parameter int TWIDTH  = 11
) (
   input  logic             clock,
   input  logic             reset,
   spw_tx_arbiter_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE, WAIT, WRITE, GAP, TMO, INJ, INJ_GAP
   } state_t;

   // Last count of the watchdog before it fires.
   localparam logic [TWIDTH-1:0] TMO_LAST = TWIDTH'(TIMEOUT - 1);
   // N-char flag in the top bit, low byte 0x01 selects EEP.
   localparam logic [DWIDTH-1:0] EEP_WORD = {1'b1, {(DWIDTH-1){1'b0}}} | DWIDTH'(1);

   state_t            state_q;
   logic [1:0]        grant_q;
   logic              last_owner_q;   // 0 = req0, 1 = req1
   logic [TWIDTH-1:0] timer_q;
   logic [7:0]        err_cnt_q;
   logic              wr_en_q;
   logic [DWIDTH-1:0] data_q;
   logic              ack0_q;
   logic              ack1_q;
   logic              tmo_q;

   logic              owner_valid;
   logic [DWIDTH-1:0] owner_data;
   logic              pick_req1;
   logic [7:0]        err_cnt_d;
   logic [TWIDTH-1:0] timer_d;

   // Select the current owner's request, resolve arbitration and prepare counter increments.
   always_comb begin
      owner_valid = grant_q[1] ? bus.req1_valid : bus.req0_valid;
      owner_data  = grant_q[1] ? bus.req1_data  : bus.req0_data;
      // req1 wins when it is alone, or when both ask and req0 owned last.
      pick_req1   = bus.req1_valid & (~bus.req0_valid | ~last_owner_q);
      err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
      timer_d     = timer_q + TWIDTH'(1);
   end

   // Arbitration FSM; every output is a register updated here.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         grant_q      <= 2'b00;
         last_owner_q <= 1'b1;
         timer_q      <= '0;
         err_cnt_q    <= 8'd0;
         wr_en_q      <= 1'b0;
         data_q       <= '0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         tmo_q        <= 1'b0;
      end else begin
         // Strobes and pulses are single-cycle unless re-asserted below.
         wr_en_q <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         tmo_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req0_valid || bus.req1_valid) begin
                  grant_q <= pick_req1 ? 2'b10 : 2'b01;
                  timer_q <= '0;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (owner_valid) begin
                  // A full FIFO simply stalls; the watchdog neither counts nor clears.
                  if (!bus.fifo_full) begin
                     wr_en_q <= 1'b1;
                     data_q  <= owner_data;
                     timer_q <= '0;
                     state_q <= WRITE;
                  end
               end else if (timer_q == TMO_LAST) begin
                  tmo_q     <= 1'b1;
                  err_cnt_q <= err_cnt_d;
                  timer_q   <= '0;
                  state_q   <= TMO;
               end else begin
                  timer_q <= timer_d;
               end
            end
            WRITE: begin
               ack0_q  <= ~grant_q[1];
               ack1_q  <= grant_q[1];
               state_q <= GAP;
            end
            GAP: begin
               // data_q still holds the word just written.
               if (data_q[DWIDTH-1]) begin
                  grant_q      <= 2'b00;
                  last_owner_q <= grant_q[1];
                  state_q      <= IDLE;
               end else begin
                  state_q <= WAIT;
               end
            end
            TMO: begin
               // Owner stays blocked while the EEP waits for FIFO space.
               if (!bus.fifo_full) begin
                  wr_en_q <= 1'b1;
                  data_q  <= EEP_WORD;
                  state_q <= INJ;
               end
            end
            INJ: begin
               state_q <= INJ_GAP;
            end
            INJ_GAP: begin
               grant_q      <= 2'b00;
               last_owner_q <= grant_q[1];
               state_q      <= IDLE;
            end
            default: begin
               grant_q <= 2'b00;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.fifo_wr_en  = wr_en_q;
   assign bus.fifo_data   = data_q;
   assign bus.req0_ack    = ack0_q;
   assign bus.req1_ack    = ack1_q;
   assign bus.grant       = grant_q;
   assign bus.timeout_err = tmo_q;
   assign bus.err_cnt     = err_cnt_q;

endmodule
